// File: rtl/fifo_prog_pkg.sv
// Shared types and elaboration helpers for the programmable-threshold FIFO.
// Derives the count width and validates the chosen depth.
package fifo_prog_pkg;

   typedef enum logic {
      READ_REG  = 1'b0,
      READ_FWFT = 1'b1
   } read_mode_e;

   // Occupancy ranges 0..depth inclusive, hence depth+1 codes.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit depth_ok(input int depth);
      return depth >= 2;
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer that wraps from DEPTH-1 back to 0.
// Depth need not be a power of two.
module fifo_wrap_ptr #(
   parameter int DEPTH = 8,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_in,
   input  logic             sreset,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] r_ptr;

   // Wrap is an explicit compare so that non-power-of-two depths index correctly.
   always_ff @(posedge clk_in) begin
      if (sreset) begin
         r_ptr <= '0;
      end else if (inc) begin
         if (r_ptr == PTR_W'(DEPTH - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= r_ptr + PTR_W'(1);
         end
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/fifo_mem_prog.sv
// Single-clock FIFO of arbitrary depth with registered or fall-through reads,
// occupancy count, programmable almost thresholds and sticky error flags.
module fifo_mem_prog
   import fifo_prog_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int FWFT       = 0,
   parameter int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk_in,
   input  logic                  sreset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   input  logic                  clr_err,
   output logic [CNT_W-1:0]      count,
   output logic                  full_ind,
   output logic                  empty_ind,
   output logic                  almost_full_ind,
   output logic                  almost_empty_ind,
   output logic                  overflow_ind,
   output logic                  underflow_ind
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam read_mode_e MODE = (FWFT != 0) ? READ_FWFT : READ_REG;

   generate
      if (!depth_ok(DEPTH)) begin : g_bad_depth
         $error("fifo_mem_prog: DEPTH must be at least 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]      r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [PTR_W-1:0]      w_wrPtr;
   logic [PTR_W-1:0]      w_rdPtr;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_rdAccept;
   logic                  w_wrAccept;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_rdAccept = rd_en && !w_empty;
   // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
   assign w_wrAccept = wr_en && (!w_full || w_rdAccept);

   fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wrPtr (
      .clk_in (clk_in),
      .sreset (sreset),
      .inc    (w_wrAccept),
      .ptr    (w_wrPtr)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rdPtr (
      .clk_in (clk_in),
      .sreset (sreset),
      .inc    (w_rdAccept),
      .ptr    (w_rdPtr)
   );

   always_ff @(posedge clk_in) begin
      if (!sreset && w_wrAccept) begin
         r_mem[w_wrPtr] <= wr_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (sreset) begin
         r_count <= '0;
      end else if (w_wrAccept && !w_rdAccept) begin
         r_count <= r_count + CNT_W'(1);
      end else if (w_rdAccept && !w_wrAccept) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // A new rejection outranks a clear arriving in the same cycle.
   always_ff @(posedge clk_in) begin
      if (sreset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && !w_wrAccept) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (rd_en && !w_rdAccept) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   generate
      if (MODE == READ_REG) begin : g_readReg
         logic [DATA_WIDTH-1:0] r_rdData;
         logic                  r_rdValid;

         always_ff @(posedge clk_in) begin
            if (sreset) begin
               r_rdData  <= '0;
               r_rdValid <= 1'b0;
            end else begin
               r_rdValid <= w_rdAccept;
               if (w_rdAccept) begin
                  r_rdData <= r_mem[w_rdPtr];
               end
            end
         end

         assign rd_data  = r_rdData;
         assign rd_valid = r_rdValid;
      end else begin : g_readFwft
         assign rd_data  = r_mem[w_rdPtr];
         assign rd_valid = !w_empty;
      end
   endgenerate

   assign count            = r_count;
   assign full_ind         = w_full;
   assign empty_ind        = w_empty;
   assign almost_full_ind  = (r_count >= af_thresh);
   assign almost_empty_ind = (r_count <= ae_thresh);
   assign overflow_ind     = r_overflow;
   assign underflow_ind    = r_underflow;

endmodule

// File: tb/tb_fifo_mem_prog.sv
// Drives a registered-read DEPTH=5 FIFO and a fall-through DEPTH=4 FIFO in lockstep
// and compares both against queue-based reference models.
module tb_fifo_mem_prog;

   localparam int DW = 32;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          sreset;
   logic          wrEn;
   logic [DW-1:0] wrData;
   logic          rdEn;
   logic [CW-1:0] afTh;
   logic [CW-1:0] aeTh;
   logic          clrErr;

   logic [DW-1:0] rdData0, rdData1;
   logic          rdValid0, rdValid1;
   logic [CW-1:0] count0, count1;
   logic          full0, full1, empty0, empty1;
   logic          af0, af1, ae0, ae1;
   logic          ovf0, ovf1, unf0, unf1;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq0[$];
   logic [DW-1:0] mq1[$];
   logic          mOvf0, mUnf0, mOvf1, mUnf1, mRv0;
   logic [DW-1:0] mRd0;

   always #5 clk = ~clk;

   fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(5), .FWFT(0)) dutReg (
      .clk_in(clk), .sreset(sreset), .wr_en(wrEn), .wr_data(wrData), .rd_en(rdEn),
      .rd_data(rdData0), .rd_valid(rdValid0), .af_thresh(afTh), .ae_thresh(aeTh),
      .clr_err(clrErr), .count(count0), .full_ind(full0), .empty_ind(empty0),
      .almost_full_ind(af0), .almost_empty_ind(ae0),
      .overflow_ind(ovf0), .underflow_ind(unf0)
   );

   fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(4), .FWFT(1)) dutFwft (
      .clk_in(clk), .sreset(sreset), .wr_en(wrEn), .wr_data(wrData), .rd_en(rdEn),
      .rd_data(rdData1), .rd_valid(rdValid1), .af_thresh(afTh), .ae_thresh(aeTh),
      .clr_err(clrErr), .count(count1), .full_ind(full1), .empty_ind(empty1),
      .almost_full_ind(af1), .almost_empty_ind(ae1),
      .overflow_ind(ovf1), .underflow_ind(unf1)
   );

   // Reference behaviour: a FIFO is an ordered queue bounded by its depth.
   task automatic modelStep();
      bit rAcc, wAcc;
      if (sreset) begin
         mq0.delete(); mq1.delete();
         mOvf0 = 0; mUnf0 = 0; mOvf1 = 0; mUnf1 = 0;
         mRd0 = '0; mRv0 = 0;
      end else begin
         rAcc = rdEn && (mq0.size() > 0);
         wAcc = wrEn && (mq0.size() < 5 || rAcc);
         mRv0 = rAcc;
         if (rAcc) mRd0 = mq0.pop_front();
         if (wAcc) mq0.push_back(wrData);
         mOvf0 = (wrEn && !wAcc) ? 1'b1 : (clrErr ? 1'b0 : mOvf0);
         mUnf0 = (rdEn && !rAcc) ? 1'b1 : (clrErr ? 1'b0 : mUnf0);

         rAcc = rdEn && (mq1.size() > 0);
         wAcc = wrEn && (mq1.size() < 4 || rAcc);
         if (rAcc) void'(mq1.pop_front());
         if (wAcc) mq1.push_back(wrData);
         mOvf1 = (wrEn && !wAcc) ? 1'b1 : (clrErr ? 1'b0 : mOvf1);
         mUnf1 = (rdEn && !rAcc) ? 1'b1 : (clrErr ? 1'b0 : mUnf1);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      int n0, n1;
      n0 = mq0.size();
      n1 = mq1.size();
      checkOutput("reg.count", 32'(count0), 32'(n0));
      checkOutput("reg.full", 32'(full0), 32'(n0 == 5));
      checkOutput("reg.empty", 32'(empty0), 32'(n0 == 0));
      checkOutput("reg.afull", 32'(af0), 32'(n0 >= int'(afTh)));
      checkOutput("reg.aempty", 32'(ae0), 32'(n0 <= int'(aeTh)));
      checkOutput("reg.ovf", 32'(ovf0), 32'(mOvf0));
      checkOutput("reg.unf", 32'(unf0), 32'(mUnf0));
      checkOutput("reg.rdValid", 32'(rdValid0), 32'(mRv0));
      checkOutput("reg.rdData", rdData0, mRd0);
      checkOutput("fwft.count", 32'(count1), 32'(n1));
      checkOutput("fwft.full", 32'(full1), 32'(n1 == 4));
      checkOutput("fwft.empty", 32'(empty1), 32'(n1 == 0));
      checkOutput("fwft.afull", 32'(af1), 32'(n1 >= int'(afTh)));
      checkOutput("fwft.aempty", 32'(ae1), 32'(n1 <= int'(aeTh)));
      checkOutput("fwft.ovf", 32'(ovf1), 32'(mOvf1));
      checkOutput("fwft.unf", 32'(unf1), 32'(mUnf1));
      checkOutput("fwft.rdValid", 32'(rdValid1), 32'(n1 > 0));
      if (n1 > 0) checkOutput("fwft.rdData", rdData1, mq1[0]);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re,
                                input logic clr, input logic rst);
      @(negedge clk);
      wrEn = we; wrData = wd; rdEn = re; clrErr = clr; sreset = rst;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   initial begin
      sreset = 1'b1; wrEn = 0; wrData = '0; rdEn = 0; clrErr = 0;
      afTh = 3'd4; aeTh = 3'd1;
      mq0.delete(); mq1.delete();
      mOvf0 = 0; mUnf0 = 0; mOvf1 = 0; mUnf1 = 0; mRd0 = '0; mRv0 = 0;
      $display("[TB] starting");

      applyStimulus(0, '0, 0, 0, 1);
      applyStimulus(0, '0, 0, 0, 1);

      // Fill past capacity, then drain in order.
      for (int k = 1; k <= 6; k++) applyStimulus(1, 32'(k * 'h11), 0, 0, 0);
      for (int k = 0; k < 6; k++) applyStimulus(0, '0, 1, 0, 0);
      applyStimulus(0, '0, 0, 1, 0);

      // Alternating pairs walk the pointers across the wrap point.
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1, $urandom, 0, 0, 0);
         applyStimulus(0, '0, 1, 0, 0);
      end

      // Full plus simultaneous push/pop.
      for (int k = 0; k < 5; k++) applyStimulus(1, 32'('h100 + k), 0, 0, 0);
      applyStimulus(1, 32'h0000_0BEE, 1, 0, 0);
      applyStimulus(1, 32'h0000_0CAF, 1, 0, 0);
      for (int k = 0; k < 6; k++) applyStimulus(0, '0, 1, 0, 0);
      applyStimulus(0, '0, 0, 1, 0);

      // Empty with simultaneous push/pop, then the clear-versus-set race.
      applyStimulus(1, 32'h0000_00E1, 1, 0, 0);
      applyStimulus(0, '0, 0, 1, 0);
      applyStimulus(0, '0, 1, 0, 0);
      applyStimulus(0, '0, 1, 1, 0);
      applyStimulus(0, '0, 0, 1, 0);

      // Fall-through visibility of a single word.
      applyStimulus(1, 32'h0000_00A5, 0, 0, 0);
      applyStimulus(0, '0, 0, 0, 0);
      applyStimulus(0, '0, 1, 0, 0);

      // Threshold crossings and a reset in the middle of a fill.
      afTh = 3'd3; aeTh = 3'd1;
      for (int k = 0; k < 3; k++) applyStimulus(1, 32'('h200 + k), 0, 0, 0);
      applyStimulus(1, 32'h0000_0DEA, 0, 0, 1);
      applyStimulus(0, '0, 1, 0, 0);
      applyStimulus(0, '0, 0, 1, 0);

      // Randomised traffic, including out-of-range thresholds and sporadic resets.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            afTh = CW'($urandom_range(0, 7));
            aeTh = CW'($urandom_range(0, 7));
         end
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
